// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with N_RD registered read ports, two write
// ports (port 1 wins on address clash), write-first bypass and an optional zero register.
module regfile_mp #(
  parameter int BW_DATA  = 16,
  parameter int BW_ADDR  = 4,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_RD-1:0]         i_rf_rd_en,
  input  logic [N_RD*BW_ADDR-1:0] i_rf_rd_addr,
  output logic [N_RD*BW_DATA-1:0] o_rf_rd_data,
  output logic [N_RD-1:0]         o_rf_rd_valid,
  input  logic [1:0]              i_rf_wr_en,
  input  logic [2*BW_ADDR-1:0]    i_rf_wr_addr,
  input  logic [2*BW_DATA-1:0]    i_rf_wr_data,
  output logic                    o_rf_wr_conflict
);

  localparam int DEPTH = 2**BW_ADDR;

  logic [DEPTH-1:0][BW_DATA-1:0] r_mem;
  logic [N_RD*BW_DATA-1:0]       r_rd_data;
  logic [N_RD-1:0]               r_rd_valid;
  logic                          r_wr_conflict;

  logic [BW_ADDR-1:0] w_wa0;
  logic [BW_ADDR-1:0] w_wa1;
  logic [BW_DATA-1:0] w_wd0;
  logic [BW_DATA-1:0] w_wd1;
  logic               w_we0;
  logic               w_we1;
  logic               w_same_addr;
  logic               w_conflict;
  logic [BW_ADDR-1:0] w_ra     [N_RD];
  logic [BW_DATA-1:0] w_rd_val [N_RD];

  // True when the address is the hardwired zero entry
  function automatic logic f_is_zero(input logic [BW_ADDR-1:0] addr);
    return (ZERO_REG != 0) && (addr == {BW_ADDR{1'b0}});
  endfunction

  // Unpack write ports and qualify enables against the zero register
  always_comb begin
    w_wa0       = i_rf_wr_addr[0 +: BW_ADDR];
    w_wa1       = i_rf_wr_addr[BW_ADDR +: BW_ADDR];
    w_wd0       = i_rf_wr_data[0 +: BW_DATA];
    w_wd1       = i_rf_wr_data[BW_DATA +: BW_DATA];
    w_we0       = i_rf_wr_en[0] && !f_is_zero(w_wa0);
    w_we1       = i_rf_wr_en[1] && !f_is_zero(w_wa1);
    w_same_addr = (w_wa0 == w_wa1);
    w_conflict  = (i_rf_wr_en == 2'b11) && w_same_addr && !f_is_zero(w_wa0);
  end

  // Per-port next read value; port 1 is checked first so it wins the bypass
  always_comb begin
    for (int k = 0; k < N_RD; k++) begin
      w_ra[k] = i_rf_rd_addr[k*BW_ADDR +: BW_ADDR];
      if (f_is_zero(w_ra[k])) begin
        w_rd_val[k] = {BW_DATA{1'b0}};
      end else if (w_we1 && (w_wa1 == w_ra[k])) begin
        w_rd_val[k] = w_wd1;
      end else if (w_we0 && (w_wa0 == w_ra[k])) begin
        w_rd_val[k] = w_wd0;
      end else begin
        w_rd_val[k] = r_mem[w_ra[k]];
      end
    end
  end

  // Storage array: clear on reset, port 0 dropped when port 1 hits the same entry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem <= '0;
    end else begin
      if (w_we0 && !(w_we1 && w_same_addr)) begin
        r_mem[w_wa0] <= w_wd0;
      end
      if (w_we1) begin
        r_mem[w_wa1] <= w_wd1;
      end
    end
  end

  // Registered read data/valid and conflict pulse; data holds while a port is idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data     <= '0;
      r_rd_valid    <= '0;
      r_wr_conflict <= 1'b0;
    end else begin
      for (int k = 0; k < N_RD; k++) begin
        r_rd_valid[k] <= i_rf_rd_en[k];
        if (i_rf_rd_en[k]) begin
          r_rd_data[k*BW_DATA +: BW_DATA] <= w_rd_val[k];
        end
      end
      r_wr_conflict <= w_conflict;
    end
  end

  assign o_rf_rd_data     = r_rd_data;
  assign o_rf_rd_valid    = r_rd_valid;
  assign o_rf_wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a plain ZERO_REG=0 instance and a ZERO_REG=1 instance
// share stimulus; an array model predicts every cycle's outputs for both.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;

  logic [31:0] rd_data_n, rd_data_z;
  logic [1:0]  rd_valid_n, rd_valid_z;
  logic        conflict_n, conflict_z;

  always #5 clk = ~clk;

  regfile_mp #(.BW_DATA(16), .BW_ADDR(4), .N_RD(2), .ZERO_REG(0)) dut_n (
    .i_clk(clk), .i_rst(rst), .i_rf_rd_en(rd_en), .i_rf_rd_addr(rd_addr),
    .o_rf_rd_data(rd_data_n), .o_rf_rd_valid(rd_valid_n), .i_rf_wr_en(wr_en),
    .i_rf_wr_addr(wr_addr), .i_rf_wr_data(wr_data), .o_rf_wr_conflict(conflict_n));

  regfile_mp #(.BW_DATA(16), .BW_ADDR(4), .N_RD(2), .ZERO_REG(1)) dut_z (
    .i_clk(clk), .i_rst(rst), .i_rf_rd_en(rd_en), .i_rf_rd_addr(rd_addr),
    .o_rf_rd_data(rd_data_z), .o_rf_rd_valid(rd_valid_z), .i_rf_wr_en(wr_en),
    .i_rf_wr_addr(wr_addr), .i_rf_wr_data(wr_data), .o_rf_wr_conflict(conflict_z));

  typedef struct {
    logic [1:0]  vn;
    logic [31:0] dn;
    logic        cn;
    logic [1:0]  vz;
    logic [31:0] dz;
    logic        cz;
  } exp_t;

  exp_t q[$];
  exp_t em;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] m_n[16];
  logic [15:0] m_z[16];
  logic [15:0] hold_n[2];
  logic [15:0] hold_z[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle: drive inputs, advance the model, queue the expected outputs
  task automatic cyc(input logic r, input logic [1:0] re, input logic [3:0] ra0,
                     input logic [3:0] ra1, input logic [1:0] we, input logic [3:0] wa0,
                     input logic [3:0] wa1, input logic [15:0] wd0, input logic [15:0] wd1);
    exp_t e;
    logic [3:0] ra[2];
    rst = r; rd_en = re; rd_addr = {ra1, ra0};
    wr_en = we; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
    ra[0] = ra0; ra[1] = ra1;
    if (r) begin
      for (int i = 0; i < 16; i++) begin m_n[i] = 16'h0; m_z[i] = 16'h0; end
      for (int k = 0; k < 2; k++) begin hold_n[k] = 16'h0; hold_z[k] = 16'h0; end
      e.vn = 2'b00; e.vz = 2'b00; e.cn = 1'b0; e.cz = 1'b0;
    end else begin
      // write-first: apply writes (port 1 last so it wins), then read the updated array
      if (we[0]) m_n[wa0] = wd0;
      if (we[1]) m_n[wa1] = wd1;
      if (we[0] && wa0 != 4'd0) m_z[wa0] = wd0;
      if (we[1] && wa1 != 4'd0) m_z[wa1] = wd1;
      for (int k = 0; k < 2; k++) begin
        if (re[k]) begin
          hold_n[k] = m_n[ra[k]];
          hold_z[k] = m_z[ra[k]];
        end
      end
      e.vn = re; e.vz = re;
      e.cn = (we == 2'b11) && (wa0 == wa1);
      e.cz = e.cn && (wa0 != 4'd0);
    end
    e.dn = {hold_n[1], hold_n[0]};
    e.dz = {hold_z[1], hold_z[0]};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
  endtask

  // Monitor: one expected entry per clock, compared away from the active edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      em = q.pop_front();
      chk("valid_n", {30'd0, rd_valid_n}, {30'd0, em.vn});
      chk("data_n", rd_data_n, em.dn);
      chk("conflict_n", {31'd0, conflict_n}, {31'd0, em.cn});
      chk("valid_z", {30'd0, rd_valid_z}, {30'd0, em.vz});
      chk("data_z", rd_data_z, em.dz);
      chk("conflict_z", {31'd0, conflict_z}, {31'd0, em.cz});
    end
  end

  initial begin
    int drain;
    #1;
    cyc(1'b1, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    // 1: fill via port 0, read back crosswise
    for (int i = 0; i < 16; i++)
      cyc(1'b0, 2'b00, 4'd0, 4'd0, 2'b01, 4'(i), 4'd0, 16'h1000 + 16'(i), 16'h0);
    for (int i = 0; i < 16; i++)
      cyc(1'b0, 2'b11, 4'(i), 4'(15 - i), 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    // 2: same-address and distinct-address dual writes
    cyc(1'b0, 2'b00, 4'd0, 4'd0, 2'b11, 4'd5, 4'd5, 16'hAAAA, 16'h5555);
    idle();
    cyc(1'b0, 2'b00, 4'd0, 4'd0, 2'b11, 4'd3, 4'd9, 16'h0003, 16'h0009);
    cyc(1'b0, 2'b11, 4'd5, 4'd3, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    cyc(1'b0, 2'b11, 4'd9, 4'd5, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    // 3: bypass on both read ports
    cyc(1'b0, 2'b00, 4'd0, 4'd0, 2'b01, 4'd7, 4'd0, 16'h1111, 16'h0);
    cyc(1'b0, 2'b11, 4'd7, 4'd7, 2'b01, 4'd7, 4'd0, 16'h2222, 16'h0);
    // 4: read then hold with enable dropped
    cyc(1'b0, 2'b00, 4'd0, 4'd0, 2'b10, 4'd0, 4'd2, 16'h0, 16'h0002);
    cyc(1'b0, 2'b01, 4'd2, 4'd0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    cyc(1'b0, 2'b00, 4'd4, 4'd0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    cyc(1'b0, 2'b00, 4'd4, 4'd0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    // 5: address 0 writes, bypassed reads and a dual write to 0
    cyc(1'b0, 2'b11, 4'd0, 4'd0, 2'b01, 4'd0, 4'd0, 16'hFFFF, 16'h0);
    cyc(1'b0, 2'b11, 4'd0, 4'd0, 2'b11, 4'd0, 4'd0, 16'h1234, 16'hFFFF);
    cyc(1'b0, 2'b11, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    // 6: reset with write and read pending, then full readback
    cyc(1'b0, 2'b11, 4'd1, 4'd2, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    cyc(1'b1, 2'b11, 4'd1, 4'd1, 2'b01, 4'd1, 4'd0, 16'hBEEF, 16'h0);
    for (int i = 0; i < 16; i++)
      cyc(1'b0, 2'b11, 4'(i), 4'(15 - i), 2'b00, 4'd0, 4'd0, 16'h0, 16'h0);
    // random traffic with a narrow address range half the time to provoke clashes
    for (int n = 0; n < 400; n++) begin
      logic [3:0] a0, a1, r0, r1;
      logic       narrow;
      narrow = 1'($urandom_range(0, 1));
      a0 = narrow ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      a1 = narrow ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      r0 = narrow ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      r1 = narrow ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 49) == 0), 2'($urandom), r0, r1, 2'($urandom), a0, a1,
          16'($urandom), 16'($urandom));
    end
    idle();
    drain = 0;
    while (q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #6;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, the successor to the 2R/1W regfile.
- Generalises the read-port count (N_RD) and has two write ports with fixed priority.
- Reads are registered (1-cycle latency) with write-first bypass.
- Provides synchronous clear, an optional hardwired zero register and a write-conflict flag.
- Sits beside datapath/ALU blocks as the architectural register store.

Parameters:
BW_DATA, 16, data width per entry in bits
BW_ADDR, 4, address width; depth = 2**BW_ADDR entries
N_RD, 2, number of read ports (1..8)
ZERO_REG, 0, 1 = entry 0 reads as 0 and ignores writes

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  synchronous reset, active-high
i_rf_rd_en  input  N_RD  per-port read enable
i_rf_rd_addr  input  N_RD*BW_ADDR  packed read addresses, port k at [k*BW_ADDR +: BW_ADDR]
o_rf_rd_data  output  N_RD*BW_DATA  packed registered read data, port k at [k*BW_DATA +: BW_DATA]
o_rf_rd_valid  output  N_RD  per-port read-data valid
i_rf_wr_en  input  2  write enables, bit 1 = port 1
i_rf_wr_addr  input  2*BW_ADDR  packed write addresses
i_rf_wr_data  input  2*BW_DATA  packed write data
o_rf_wr_conflict  output  1  registered flag: both write ports hit the same address last cycle

Behaviour:
- One clock (i_clk). Reset i_rst is synchronous and active-high.
- Reset (i_rst=1 at a rising edge):
  - All 2**BW_ADDR entries cleared to 0.
  - o_rf_rd_data = 0, o_rf_rd_valid = 0, o_rf_wr_conflict = 0.
  - Reset dominates: writes and reads presented in the same cycle are discarded.
- Write (per rising edge, i_rst=0):
  - Port p with i_rf_wr_en[p]=1 writes its data to its address.
  - Both ports enabled to the same address: port 1's data is stored; port 0 is dropped.
  - Both ports enabled to different addresses: both writes land in the same cycle.
- ZERO_REG=1:
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0, including the bypass path.
- Read port k (per rising edge, i_rst=0):
  - i_rf_rd_en[k]=1: o_rf_rd_data[k] <= entry value; o_rf_rd_valid[k] <= 1. Latency is exactly 1 cycle from address presentation.
  - i_rf_rd_en[k]=0: o_rf_rd_valid[k] <= 0; o_rf_rd_data[k] holds its previous value.
- Bypass (write-first):
  - If a write targets the read address in the same cycle, the read returns the newly written data.
  - Port-1 priority applies to the bypass value as well.
  - Bypass is suppressed for address 0 when ZERO_REG=1.
- Read ports are fully independent. Any number of ports may read the same address in the same cycle.
- Conflict flag:
  - o_rf_wr_conflict <= i_rf_wr_en==2'b11 && addr0==addr1 && !(ZERO_REG && addr0==0).
  - It is a one-cycle pulse per conflicting cycle.
- Address width is exact (2**BW_ADDR entries), so there is no out-of-range case. All arithmetic is unsigned; no wrap logic is needed.
- Reset mid-operation:
  - A read issued in the reset cycle produces valid=0 in the next cycle.
  - A read issued in the first cycle after reset returns 0.
- No combinational path from inputs to outputs.

Test Plan:
All scenarios use BW_DATA=16, BW_ADDR=4, N_RD=2, ZERO_REG=0 unless stated otherwise.
1. Fill and readback: write addr i = 16'h1000+i via port 0 for i=0..15, then read port0=i and port1=15-i. Required: the cycle after each read shows o_rf_rd_data[0]=16'h1000+i, o_rf_rd_data[1]=16'h100F-i, valid=2'b11.
2. Dual-write conflict: same cycle, port0 writes addr 5 = 16'hAAAA and port1 writes addr 5 = 16'h5555. Required: next cycle o_rf_wr_conflict=1 (0 the cycle after); a later read of addr 5 returns 16'h5555. Different addresses (3 = 16'h0003, 9 = 16'h0009) leave conflict at 0 and both values are stored.
3. Bypass: addr 7 holds 16'h1111; in one cycle write addr 7 = 16'h2222 and read addr 7 on both ports. Required: next cycle both ports return 16'h2222, valid=2'b11.
4. Read enable and hold: read addr 2 (=16'h0002) on port 0, then deassert i_rf_rd_en[0] and change addr to 4. Required: valid[0] drops to 0 and o_rf_rd_data[0] stays 16'h0002.
5. ZERO_REG=1: write addr 0 = 16'hFFFF (also with a same-cycle read of addr 0), and have both ports write addr 0 in one cycle. Required: reads of addr 0 return 16'h0000, and o_rf_wr_conflict stays 0.
6. Reset mid-operation: after scenario 1, assert i_rst for 1 cycle together with a write of addr 1 = 16'hBEEF and a read. Required: outputs and valid are 0; subsequent reads of all 16 addresses return 16'h0000.
